jk_mod_counter: RTL and testbench

//  Synchronous loadable up/down modulo-N counter built from a bank of JK toggle stages.

---
 rtl/jk_mod_counter.sv | 102 ++++++++++
 tb/tb_jk_mod_counter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// Loadable up/down modulo-MODULUS counter whose state bits are JK stages with J=K=toggle.
// tc_out is combinational so a higher digit can use it directly as its enable.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             tc_out
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] toggle;
    logic             carry_next;
    logic             borrow_next;
    logic             carry_reg;
    logic             borrow_reg;
    logic             at_max;
    logic             at_zero;
    logic             out_of_range;

    assign at_max       = (count == MAX_COUNT);
    assign at_zero      = (count == '0);
    assign out_of_range = (count > MAX_COUNT);

    // Target state for this edge; reset is applied directly in the stages.
    always_comb begin
        count_next  = count;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (load) begin
            count_next = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (at_max) begin
                    count_next = '0;
                    carry_next = 1'b1;
                end else if (out_of_range) begin
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    count_next  = MAX_COUNT;
                    borrow_next = 1'b1;
                end else if (out_of_range) begin
                    count_next = MAX_COUNT;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    assign toggle = count ^ count_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            logic j_bit;
            logic k_bit;
            logic q_reg;

            assign j_bit = toggle[gi];
            assign k_bit = toggle[gi];

            always_ff @(posedge clock) begin
                if (reset) begin
                    q_reg <= 1'b0;
                end else begin
                    q_reg <= (j_bit & ~q_reg) | (~k_bit & q_reg);
                end
            end

            assign count[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
        end else begin
            carry_reg  <= carry_next;
            borrow_reg <= borrow_next;
        end
    end

    assign carry_out  = carry_reg;
    assign borrow_out = borrow_reg;
    assign tc_out     = enable & ((up_down & at_max) | (~up_down & at_zero));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed and random checks of jk_mod_counter against an arithmetic modulo model,
// plus a two-digit cascade counted as a plain integer modulo 100.
module tb_jk_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clock = 1'b0;
    logic         reset, enable, up_down, load;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         carry_out, borrow_out, tc_out;

    logic         casc_reset, casc_enable;
    logic [W-1:0] lo_count, hi_count;
    logic         lo_carry, lo_borrow, lo_tc;
    logic         hi_carry, hi_borrow, hi_tc;

    int total = 0;
    int bad   = 0;

    int m_count = 0;
    bit m_carry = 1'b0;
    bit m_borrow = 1'b0;

    always #5 clock = ~clock;

    jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .count(count),
        .carry_out(carry_out), .borrow_out(borrow_out), .tc_out(tc_out)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) lo (
        .clock(clock), .reset(casc_reset), .enable(casc_enable), .up_down(1'b1),
        .load(1'b0), .load_value(4'd0), .count(lo_count),
        .carry_out(lo_carry), .borrow_out(lo_borrow), .tc_out(lo_tc)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) hi (
        .clock(clock), .reset(casc_reset), .enable(lo_tc), .up_down(1'b1),
        .load(1'b0), .load_value(4'd0), .count(hi_count),
        .carry_out(hi_carry), .borrow_out(hi_borrow), .tc_out(hi_tc)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: drive, check tc before the edge, advance the model, check state after.
    task automatic step(input bit rst, input bit ld, input int lv, input bit en, input bit ud);
        int exp_tc;
        reset = rst; load = ld; load_value = W'(lv); enable = en; up_down = ud;
        #1;
        exp_tc = (en && ((ud && m_count == MOD - 1) || (!ud && m_count == 0))) ? 1 : 0;
        check("tc_out", int'(tc_out), exp_tc);
        @(posedge clock);
        if (rst) begin
            m_count = 0; m_carry = 0; m_borrow = 0;
        end else if (ld) begin
            m_count = (lv > MOD - 1) ? MOD - 1 : lv; m_carry = 0; m_borrow = 0;
        end else if (en && ud) begin
            m_carry = (m_count == MOD - 1); m_borrow = 0;
            m_count = (m_count + 1) % MOD;
        end else if (en) begin
            m_borrow = (m_count == 0); m_carry = 0;
            m_count = (m_count + MOD - 1) % MOD;
        end else begin
            m_carry = 0; m_borrow = 0;
        end
        #1;
        check("count", int'(count), m_count);
        check("carry_out", int'(carry_out), int'(m_carry));
        check("borrow_out", int'(borrow_out), int'(m_borrow));
        check("pulse_exclusive", int'(carry_out & borrow_out), 0);
        $display("step rst=%0b ld=%0b lv=%0d en=%0b ud=%0b -> count=%0d carry=%0b borrow=%0b",
                 rst, ld, lv, en, ud, count, carry_out, borrow_out);
    endtask

    initial begin
        int pulses;
        int dec_val;
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; up_down = 1'b1;
        casc_reset = 1'b1; casc_enable = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 1);
        check("reset_count", int'(count), 0);

        // Up count: 12 enabled edges, wrap 9 -> 0 with one carry pulse
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
        check("up12_count", int'(count), 2);

        // Down count from reset: 0 -> 9 with borrow, then 8, 7
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("down3_count", int'(count), 7);

        // Load beats enable; out-of-range load saturates
        step(0, 1, 7, 1, 1);
        check("load7", int'(count), 7);
        step(0, 1, 12, 1, 0);
        check("load12_sat", int'(count), 9);
        step(0, 1, 15, 0, 1);
        check("load15_sat", int'(count), 9);

        // Hold at 5 for 4 cycles
        step(0, 1, 5, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        check("hold5", int'(count), 5);

        // Reset mid-count beats load and enable, then counting resumes
        step(0, 1, 8, 0, 1);
        step(1, 1, 3, 1, 1);
        check("reset_mid", int'(count), 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("resume2", int'(count), 2);

        // Direction change mid-count
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 1) == 1);
        end

        // Two-digit cascade: low tc drives high enable, value tracks i mod 100
        #1;
        @(posedge clock);
        #1;
        casc_reset = 1'b0; casc_enable = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            dec_val = int'(hi_count) * 10 + int'(lo_count);
            check("cascade_value", dec_val, i % 100);
            if (hi_carry) pulses++;
        end
        $display("cascade hi=%0d lo=%0d hi_carry_pulses=%0d", hi_count, lo_count, pulses);
        check("cascade_hi", int'(hi_count), 0);
        check("cascade_lo", int'(lo_count), 0);
        check("cascade_pulses", pulses, 1);
        casc_enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
